// File: rtl/fetch_stage.sv
// Fetch-stage controller: owns the PC, reads the instruction memory
// asynchronously, and fills the IF/ID pipeline register. Handles decode
// stalls, branch redirects and a halt word that freezes fetch.
module fetch_stage #(
  parameter int unsigned PC_WIDTH          = 32,
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned MEMORY_SIZE       = 1024,
  parameter int unsigned RESET_PC          = 0,
  parameter logic [INSTRUCTION_WIDTH-1:0] HALT_ENCODING = 32'hFFFFFFFF,
  parameter int unsigned COUNT_WIDTH       = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         branchTaken,
  input  logic [PC_WIDTH-1:0]          branchTarget,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]          PC,
  output logic [INSTRUCTION_WIDTH-1:0] IF_ID_instruction,
  output logic [PC_WIDTH-1:0]          IF_ID_PC,
  output logic                         IF_ID_valid,
  output logic                         halted,
  output logic [COUNT_WIDTH-1:0]       fetchCount
);

  // MEMORY_SIZE is a power of two, so masking gives the word index modulo depth.
  localparam logic [PC_WIDTH-1:0] ADDR_MASK = PC_WIDTH'(MEMORY_SIZE - 1);
  localparam logic [PC_WIDTH-1:0] LAST_PC   = PC_WIDTH'(MEMORY_SIZE - 1);
  localparam logic [PC_WIDTH-1:0] RST_PC    = PC_WIDTH'(RESET_PC);

  typedef enum logic {RUN, HALTED} state_t;

  state_t                         state_q, state_d;
  logic [PC_WIDTH-1:0]            pc_q, pc_d;
  logic [INSTRUCTION_WIDTH-1:0]   ifid_instr_q, ifid_instr_d;
  logic [PC_WIDTH-1:0]            ifid_pc_q, ifid_pc_d;
  logic                           ifid_valid_q, ifid_valid_d;
  logic                           halted_q, halted_d;
  logic [COUNT_WIDTH-1:0]         count_q, count_d;

  // State register: every piece of fetch state, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RST_PC;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
      count_q      <= count_d;
    end
  end

  // Next-state logic in priority order: branch > stall > halted > normal fetch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    halted_d     = halted_q;
    count_d      = count_q;

    if (branchTaken) begin
      // Redirect squashes the wrong-path word and clears any speculative halt.
      pc_d         = branchTarget & ADDR_MASK;
      ifid_valid_d = 1'b0;
      state_d      = RUN;
      halted_d     = 1'b0;
    end else if (stall) begin
      // Hold everything for the decode hazard.
    end else if (state_q == HALTED) begin
      ifid_valid_d = 1'b0;
    end else begin
      ifid_instr_d = instruction;
      ifid_pc_d    = pc_q;
      ifid_valid_d = 1'b1;
      count_d      = count_q + COUNT_WIDTH'(1);
      if (instruction == HALT_ENCODING) begin
        // Halt word is delivered and counted, then fetch freezes on it.
        state_d  = HALTED;
        halted_d = 1'b1;
      end else begin
        pc_d = (pc_q == LAST_PC) ? '0 : pc_q + PC_WIDTH'(1);
      end
    end
  end

  assign PC                = pc_q;
  assign IF_ID_instruction = ifid_instr_q;
  assign IF_ID_PC          = ifid_pc_q;
  assign IF_ID_valid       = ifid_valid_q;
  assign halted            = halted_q;
  assign fetchCount        = count_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch-stage controller that sits directly upstream of the instruction memory.
- Owns the program counter and drives it, as a word index, to the instruction memory's asynchronous read port.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles decode stalls, branch redirects from later stages, and a halt instruction that freezes fetch.

Parameters:
PC_WIDTH, 32, width of PC and branch target
INSTRUCTION_WIDTH, 32, width of instruction word
MEMORY_SIZE, 1024, instruction memory depth in words; must be a power of two
RESET_PC, 0, PC value loaded on reset
HALT_ENCODING, 32'hFFFFFFFF, instruction word that halts fetch
COUNT_WIDTH, 32, width of fetched-instruction counter

Ports:
clk  input  1  clock; one clock domain
reset  input  1  synchronous, active-high reset
stall  input  1  decode hazard; hold PC and IF/ID contents
branchTaken  input  1  redirect request from execute; squashes the in-flight fetch
branchTarget  input  PC_WIDTH  redirect word address
instruction  input  INSTRUCTION_WIDTH  word returned combinationally by instruction memory for PC
PC  output  PC_WIDTH  current fetch word index to instruction memory
IF_ID_instruction  output  INSTRUCTION_WIDTH  registered instruction for decode
IF_ID_PC  output  PC_WIDTH  PC of IF_ID_instruction
IF_ID_valid  output  1  IF/ID holds a real instruction
halted  output  1  fetch frozen by halt instruction
fetchCount  output  COUNT_WIDTH  number of instructions written valid into IF/ID

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: PC=RESET_PC, IF_ID_instruction=0, IF_ID_PC=0, IF_ID_valid=0, halted=0, fetchCount=0, state=RUN.
- Memory interface: instruction is combinational from PC in the same cycle, with zero wait states.
- Latency: the word at PC appears on IF_ID_* one edge later.
- States:
  - RUN: normal fetch.
  - HALTED: PC frozen; IF_ID_valid=0 after the halt word is delivered.
- Per-edge priority: reset > branchTaken > stall > HALTED > normal.
- branchTaken (any state, overrides stall):
  - PC <= branchTarget mod MEMORY_SIZE (low log2(MEMORY_SIZE) bits, upper bits zero).
  - IF_ID_valid <= 0 (wrong-path word squashed).
  - state <= RUN, halted <= 0. A speculatively fetched halt must not stick.
- stall without branchTaken: PC, IF_ID_*, state, and fetchCount are all unchanged.
- Normal, RUN:
  - IF_ID_instruction <= instruction, IF_ID_PC <= PC, IF_ID_valid <= 1.
  - fetchCount increments.
  - PC <= PC+1, or 0 if PC == MEMORY_SIZE-1 (wrap).
- Halt detect: in the normal RUN update, if instruction == HALT_ENCODING:
  - The halt word is still written to IF/ID with valid=1 and counted.
  - PC holds, state <= HALTED, halted <= 1.
- HALTED without branchTaken or stall: IF_ID_valid <= 0, PC holds, fetchCount holds.
- fetchCount wraps modulo 2^COUNT_WIDTH.
- Reset asserted mid-operation, including during stall or HALTED: next edge yields the reset values.

Test Plan:
- Reset, memory words 0..3 = A,B,C,D, no stall -> PC 0,1,2,3 on successive cycles; IF_ID_instruction A,B,C one cycle behind; IF_ID_PC 0,1,2; valid=1; fetchCount=3 after 3 fetch edges.
- stall high for 2 cycles while PC=5 -> PC stays 5; IF_ID_* and fetchCount frozen; on release, fetch resumes at word 5.
- branchTaken with branchTarget=0x410 (MEMORY_SIZE 1024), stall also high -> next PC=0x010; IF_ID_valid=0 for that edge; valid word from 0x010 appears one edge later.
- PC=1023, non-halt word -> next PC=0; IF_ID_PC=1023.
- Word at 7 = 32'hFFFFFFFF -> IF_ID holds halt word with valid=1; halted=1; PC stays 7; following cycles have valid=0 and fetchCount constant. Then branchTaken to 2 -> halted=0 and fetch restarts at 2.
- Reset asserted while HALTED with fetchCount=9 -> next edge PC=RESET_PC, halted=0, valid=0, fetchCount=0.
